// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches one word per query over a
// req/ack memory handshake, pulses run when the word is latched.
module instr_fetch #(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              instr_query,
  input  logic              cpu_run,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              run,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [15:0]       cnt, cnt_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic              instr_ld;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      pc    <= RESET_PC;
      instr <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pc    <= pc_nxt;
      if (instr_ld) instr <= mem_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pc_nxt    = pc;
    instr_ld  = 1'b0;
    case (state)
      IDLE: begin
        // A same-cycle pc update and query both take effect, so the
        // following REQ cycle already addresses the updated pc.
        if (cpu_run)
          pc_nxt = branch_en ? {branch_addr[ADDR_W-1:2], 2'b00} : pc + ADDR_W'(4);
        if (instr_query) begin
          state_nxt = REQ;
          cnt_nxt   = '0;
        end
      end
      REQ: begin
        // Ack wins over a timeout expiring in the same cycle.
        if (mem_ack) begin
          instr_ld  = 1'b1;
          state_nxt = DONE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ERR;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and status outputs decode straight from the state register.
  assign mem_req   = (state == REQ);
  assign run       = (state == DONE);
  assign fetch_err = (state == ERR);
  assign mem_addr  = pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized self-checking bench for instr_fetch against a transaction-level
// sequencer/memory model (expected pc, fetched word and latency).
module tb_instr_fetch;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              instr_query, cpu_run, branch_en, mem_ack;
  logic [ADDR_W-1:0] branch_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_req, run, fetch_err;
  logic [ADDR_W-1:0] mem_addr, pc;
  logic [DATA_W-1:0] instr;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] mpc;

  instr_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC('0), .TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n), .instr_query(instr_query), .cpu_run(cpu_run),
    .branch_en(branch_en), .branch_addr(branch_addr), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .run(run),
    .instr(instr), .pc(pc), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memval(input logic [31:0] a);
    return (a == 32'h0) ? 32'hDEADBEEF : ((a * 32'h9E3779B1) ^ 32'h13579BDF);
  endfunction

  // One query -> run transaction. Optionally issue cpu_run in the query cycle,
  // and optionally poke cpu_run during REQ (must be ignored).
  task automatic fetch(input int waits, input bit spur, input bit with_run,
                       input bit br, input logic [31:0] baddr);
    int t, reqs;
    bit seen_run;
    logic [31:0] exp_i;
    if (with_run) begin
      cpu_run = 1; branch_en = br; branch_addr = baddr;
      mpc = br ? {baddr[31:2], 2'b00} : mpc + 32'd4;
    end
    exp_i = memval(mpc);
    instr_query = 1;
    @(negedge clk);
    instr_query = 0; cpu_run = 0; branch_en = 0;
    check("req_cycle1", 64'(mem_req), 64'd1);
    check("mem_addr", 64'(mem_addr), 64'(mpc));
    t = 1; reqs = 0; seen_run = 0;
    while (t < 40 && !seen_run) begin
      if (run) seen_run = 1;
      else begin
        mem_ack   = mem_req && (reqs == waits);
        mem_rdata = mem_ack ? exp_i : $urandom;
        cpu_run   = spur && mem_req;
        branch_en = 1; branch_addr = $urandom;
        if (mem_req) reqs++;
        @(negedge clk);
        t++;
        mem_ack = 0; cpu_run = 0; branch_en = 0;
      end
    end
    check("run_seen", 64'(seen_run), 64'd1);
    check("latency", 64'(t), 64'(2 + waits));
    check("instr", 64'(instr), 64'(exp_i));
    check("pc_hold", 64'(pc), 64'(mpc));
    // Ack outside REQ must not disturb the latched word.
    mem_ack = 1; mem_rdata = ~exp_i;
    @(negedge clk);
    mem_ack = 0;
    check("run_width", 64'(run), 64'd0);
    check("instr_hold", 64'(instr), 64'(exp_i));
    check("req_done", 64'(mem_req), 64'd0);
  endtask

  task automatic do_run(input bit br, input logic [31:0] baddr);
    cpu_run = 1; branch_en = br; branch_addr = baddr;
    @(negedge clk);
    cpu_run = 0; branch_en = 0;
    mpc = br ? {baddr[31:2], 2'b00} : mpc + 32'd4;
    check("pc_update", 64'(pc), 64'(mpc));
  endtask

  task automatic sync_reset();
    reset_n = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    mpc = 32'h0;
  endtask

  initial begin
    int reqs;
    logic [31:0] old_pc;
    reset_n = 0; instr_query = 0; cpu_run = 0; branch_en = 0;
    branch_addr = '0; mem_ack = 0; mem_rdata = '0; mpc = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_pc", 64'(pc), 64'h0);
    check("rst_instr", 64'(instr), 64'h0);
    check("rst_req", 64'(mem_req), 64'd0);
    check("rst_run", 64'(run), 64'd0);
    check("rst_err", 64'(fetch_err), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'h0);
    reset_n = 1;

    fetch(0, 0, 0, 0, 32'h0);                      // zero-wait, DEADBEEF
    for (int i = 0; i < 3; i++) begin              // sequential 0x0,0x4,0x8
      fetch(2, 0, 0, 0, 32'h0);
      do_run(0, 32'h0);
    end
    do_run(1, 32'h103);                            // branch -> 0x100
    fetch(1, 1, 0, 0, 32'h0);
    do_run(1, 32'hFFFF_FFFE);                      // -> 0xFFFFFFFC
    do_run(0, 32'h0);                              // wrap to 0
    check("wrap_no_err", 64'(fetch_err), 64'd0);
    fetch(3, 0, 1, 1, 32'h0000_2A7);               // query + cpu_run together

    for (int i = 0; i < 12; i++) begin
      fetch($urandom_range(0, 3), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), $urandom);
      if ($urandom_range(0, 1) == 1) do_run(($urandom_range(0, 2) == 0), $urandom);
    end

    // Asynchronous reset in the middle of a fetch.
    instr_query = 1;
    @(negedge clk);
    instr_query = 0;
    check("ar_req", 64'(mem_req), 64'd1);
    @(posedge clk);
    #3 reset_n = 0;
    #1;
    check("ar_req0", 64'(mem_req), 64'd0);
    check("ar_run0", 64'(run), 64'd0);
    check("ar_pc", 64'(pc), 64'h0);
    check("ar_addr", 64'(mem_addr), 64'h0);
    check("ar_instr", 64'(instr), 64'h0);
    check("ar_err", 64'(fetch_err), 64'd0);
    @(negedge clk);
    mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    reset_n = 1;
    repeat (2) @(negedge clk);
    mem_ack = 0;
    check("ar_late_instr", 64'(instr), 64'h0);
    check("ar_late_run", 64'(run), 64'd0);
    check("ar_late_req", 64'(mem_req), 64'd0);
    mpc = 32'h0;

    // Timeout: no ack ever.
    do_run(1, 32'h0000_0040);
    old_pc = mpc;
    instr_query = 1;
    @(negedge clk);
    instr_query = 0;
    reqs = 0;
    while (mem_req && reqs < 20) begin
      reqs++;
      @(negedge clk);
    end
    check("to_req_cycles", 64'(reqs), 64'd4);
    check("to_err", 64'(fetch_err), 64'd1);
    check("to_req_drop", 64'(mem_req), 64'd0);
    for (int i = 0; i < 6; i++) begin
      mem_ack = 1; instr_query = 1; cpu_run = 1; mem_rdata = $urandom;
      @(negedge clk);
      check("err_sticky", 64'(fetch_err), 64'd1);
      check("err_no_run", 64'(run | mem_req), 64'd0);
    end
    mem_ack = 0; instr_query = 0; cpu_run = 0;
    check("err_pc_frozen", 64'(pc), 64'(old_pc));
    sync_reset();
    check("err_cleared", 64'(fetch_err), 64'd0);
    check("post_rst_pc", 64'(pc), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
